// File: rtl/spi_byte_sequencer.sv
// -----------------------------------------------------------------------------
// spi_byte_sequencer
//   Upstream feeder for an 8-bit SPI master. Host bytes are queued in a TX FIFO
//   and handed to the master one at a time. Each byte the master receives is
//   captured into an RX FIFO, which the host drains with a valid/ready handshake.
//   Only one byte is in flight at any time. A new byte is issued only when the
//   RX FIFO has room, so no received byte is ever dropped.
//
//   Optional feature (compile-time macro SPI_SEQ_TIMEOUT_EN):
//     A per-byte watchdog aborts a byte that stays in ARM/RUN for
//     TIMEOUT_CYCLES clocks. The byte is dropped and the sticky err flag is set.
//     Without the macro, err is tied low and err_clr is ignored. The port list
//     is the same in both builds.
//
// Ports
//   clk, rst        clock; synchronous active-high reset (shared with master)
//   tx_data/valid   host byte in; tx_ready = TX FIFO can accept this cycle
//   rx_data/valid   RX FIFO head out; rx_ready = host pops
//   spi_data_in     byte presented to the master (registered, held)
//   spi_ready_send  one-cycle start pulse to the master
//   spi_busy        master busy
//   spi_data_out    master received byte
//   idle            FSM idle and TX FIFO empty
//   tx_level        TX occupancy (excludes the byte held in spi_data_in)
//   rx_level        RX occupancy
//   err, err_clr    sticky timeout flag and its clear
//
// TX_DEPTH and RX_DEPTH must be powers of 2 and at least 2, because the
// pointers wrap naturally.
// -----------------------------------------------------------------------------
module spi_byte_sequencer #(
   parameter int TX_DEPTH       = 16,
   parameter int RX_DEPTH       = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [7:0]                  rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [7:0]                  spi_data_in,
   output logic                        spi_ready_send,
   input  logic                        spi_busy,
   input  logic [7:0]                  spi_data_out,
   output logic                        idle,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic                        err,
   input  logic                        err_clr
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [TAW:0] TX_FULL_LVL = (TAW+1)'(TX_DEPTH);
   localparam logic [RAW:0] RX_FULL_LVL = (RAW+1)'(RX_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_ARM,
      S_RUN,
      S_CAPTURE
   } state_t;

   state_t state;

   logic [7:0]     tx_mem [TX_DEPTH];
   logic [TAW-1:0] tx_wr_ptr;
   logic [TAW-1:0] tx_rd_ptr;
   logic [7:0]     rx_mem [RX_DEPTH];
   logic [RAW-1:0] rx_wr_ptr;
   logic [RAW-1:0] rx_rd_ptr;

   logic tx_empty, tx_full, tx_push, tx_pop;
   logic rx_empty, rx_full, rx_push, rx_pop;

   assign tx_empty = (tx_level == '0);
   assign tx_full  = (tx_level == TX_FULL_LVL);
   assign rx_empty = (rx_level == '0);
   assign rx_full  = (rx_level == RX_FULL_LVL);

   // Issue only when the RX FIFO has room. With one byte in flight, the RX
   // FIFO can therefore never overflow at CAPTURE.
   assign tx_pop   = (state == S_IDLE) && !tx_empty && !rx_full;
   // A full TX FIFO still accepts a byte when the head leaves in the same cycle.
   assign tx_ready = !tx_full || tx_pop;
   assign tx_push  = tx_valid && tx_ready;

   assign rx_push  = (state == S_CAPTURE);
   // An empty RX FIFO passes the captured byte straight through, so a
   // same-cycle pop is accepted and the level stays unchanged.
   assign rx_valid = !rx_empty || rx_push;
   assign rx_data  = rx_empty ? spi_data_out : rx_mem[rx_rd_ptr];
   assign rx_pop   = rx_valid && rx_ready;

   assign idle = (state == S_IDLE) && tx_empty;

   // FIFO storage: no reset needed. Push and pop always advance their own
   // pointers, so simultaneous operations stay consistent when the FIFO is
   // full or empty.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
      if (rx_push) rx_mem[rx_wr_ptr] <= spi_data_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_level  <= '0;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_level  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_level <= tx_level + 1'b1;
            2'b01:   tx_level <= tx_level - 1'b1;
            default: tx_level <= tx_level;
         endcase
         case ({rx_push, rx_pop})
            2'b10:   rx_level <= rx_level + 1'b1;
            2'b01:   rx_level <= rx_level - 1'b1;
            default: rx_level <= rx_level;
         endcase
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_hit;

   // The counter reaches TO_LAST on the TIMEOUT_CYCLES-th cycle spent in ARM/RUN.
   assign to_hit = ((state == S_ARM) || (state == S_RUN)) && (to_cnt == TO_LAST);
`else
   // The watchdog is absent in this build. err_clr and TIMEOUT_CYCLES are
   // intentionally unused.
   logic        unused_err_clr;
   logic [31:0] unused_timeout;
   assign unused_err_clr = err_clr;
   assign unused_timeout = TIMEOUT_CYCLES;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         spi_ready_send <= 1'b0;
         spi_data_in    <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
         to_cnt         <= '0;
         err            <= 1'b0;
`endif
      end else begin
         spi_ready_send <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tx_pop) begin
                  spi_data_in    <= tx_mem[tx_rd_ptr];
                  spi_ready_send <= 1'b1;
                  state          <= S_ISSUE;
               end
            end
            // In ISSUE the master has not yet seen the pulse, so busy=0 here
            // means nothing. Completion is only accepted after busy has risen.
            S_ISSUE:   state <= S_ARM;
            S_ARM:     if (spi_busy)  state <= S_RUN;
            S_RUN:     if (!spi_busy) state <= S_CAPTURE;
            S_CAPTURE: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
`ifdef SPI_SEQ_TIMEOUT_EN
         if (tx_pop) begin
            to_cnt <= '0;
         end else if ((state == S_ARM) || (state == S_RUN)) begin
            to_cnt <= to_cnt + 1'b1;
         end
         // A timeout overrides normal progress: the byte is dropped, with no RX push.
         if (to_hit) state <= S_IDLE;
         // Setting err has priority over a same-cycle clear.
         if (to_hit)       err <= 1'b1;
         else if (err_clr) err <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
module tb_spi_byte_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] spi_data_in;
   logic       spi_ready_send;
   logic       spi_busy;
   logic [7:0] spi_data_out;
   logic       idle;
   logic [4:0] tx_level;
   logic [4:0] rx_level;
   logic       err;
   logic       err_clr;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural master: state shared with the directed sequence
   int         rs_count   = 0;
   int         slave_hold = 3;
   int         busy_left  = 0;
   logic       pend       = 1'b0;
   logic [7:0] got        = 8'h00;
   logic [7:0] sent_q [$];
   logic [7:0] rx_got [$];
   logic [7:0] exp_q  [$];

   always #5 clk = ~clk;

   spi_byte_sequencer #(
      .TX_DEPTH(16),
      .RX_DEPTH(16),
      .TIMEOUT_CYCLES(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .spi_data_in(spi_data_in),
      .spi_ready_send(spi_ready_send),
      .spi_busy(spi_busy),
      .spi_data_out(spi_data_out),
      .idle(idle),
      .tx_level(tx_level),
      .rx_level(rx_level),
      .err(err),
      .err_clr(err_clr)
   );

   // The master latches the start pulse and raises busy on the next cycle,
   // holding it for slave_hold cycles. The reply is the sent byte XOR 0x99.
   initial begin
      spi_busy     = 1'b0;
      spi_data_out = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            spi_busy  = 1'b0;
            pend      = 1'b0;
            busy_left = 0;
         end else begin
            if (busy_left > 0) begin
               busy_left--;
               if (busy_left == 0) begin
                  spi_busy     = 1'b0;
                  spi_data_out = got ^ 8'h99;
               end
            end
            if (pend) begin
               pend      = 1'b0;
               got       = spi_data_in;
               sent_q.push_back(got);
               spi_busy  = 1'b1;
               busy_left = slave_hold;
            end
            if (spi_ready_send) begin
               pend = 1'b1;
               rs_count++;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pops RX with rx_ready held high until n bytes are in rx_got or the budget runs out.
   task automatic collect(input int n, input int limit);
      int cyc = 0;
      rx_ready = 1'b1;
      while (rx_got.size() < n && cyc < limit) begin
         if (rx_valid) rx_got.push_back(rx_data);
         tick();
         cyc++;
      end
      rx_ready = 1'b0;
      chk("collect_count", rx_got.size(), n);
   endtask

   task automatic push_byte(input logic [7:0] d);
      int w = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && w < 200) begin
         tick();
         w++;
      end
      chk("push_ready", tx_ready, 1'b1);
      tick();
      tx_valid = 1'b0;
   endtask

   initial begin
      int rs0;
      int base;
      int w;
      rst      = 1'b1;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      err_clr  = 1'b0;

      // ---- reset values ----
      tick();
      tick();
      chk("rst_tx_ready", tx_ready, 1'b1);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_ready_send", spi_ready_send, 1'b0);
      chk("rst_data_in", spi_data_in, 8'h00);
      chk("rst_idle", idle, 1'b1);
      chk("rst_err", err, 1'b0);
      chk("rst_tx_level", tx_level, 5'd0);
      chk("rst_rx_level", rx_level, 5'd0);

      // ---- single byte: push at cycle 0, pulse at cycle 2, capture at cycle 7 ----
      rst      = 1'b0;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      chk("single_tx_level1", tx_level, 5'd1);
      chk("single_rs_c1", spi_ready_send, 1'b0);
      chk("single_idle_c1", idle, 1'b0);
      tick();
      chk("single_rs_c2", spi_ready_send, 1'b1);
      chk("single_data_in", spi_data_in, 8'hA5);
      chk("single_tx_level0", tx_level, 5'd0);
      tick();
      chk("single_rs_c3", spi_ready_send, 1'b0);
      repeat (4) tick();
      chk("single_cap_valid", rx_valid, 1'b1);
      chk("single_cap_data", rx_data, 8'h3C);
      chk("single_cap_level", rx_level, 5'd0);
      tick();
      chk("single_rx_level", rx_level, 5'd1);
      chk("single_rx_data", rx_data, 8'h3C);
      chk("single_idle", idle, 1'b1);
      chk("single_pulses", rs_count, 1);
      chk("single_master_saw", sent_q[0], 8'hA5);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("single_pop_level", rx_level, 5'd0);
      chk("single_pop_valid", rx_valid, 1'b0);

      // ---- reset in the middle of RUN ----
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      tick();
      tx_data  = 8'h22;
      tick();
      tx_valid = 1'b0;
      chk("midrst_issue", spi_ready_send, 1'b1);
      tick();
      tick();
      rs0 = rs_count;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_idle", idle, 1'b1);
      chk("midrst_tx_level", tx_level, 5'd0);
      chk("midrst_rx_level", rx_level, 5'd0);
      chk("midrst_data_in", spi_data_in, 8'h00);
      repeat (15) tick();
      chk("midrst_no_rx", rx_level, 5'd0);
      chk("midrst_no_valid", rx_valid, 1'b0);
      chk("midrst_no_pulse", rs_count, rs0);

      // ---- burst 0x00..0x0F with rx_ready high ----
      rx_got.delete();
      base     = sent_q.size();
      rx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tx_data  = 8'(i);
         tx_valid = 1'b1;
         if (rx_valid) rx_got.push_back(rx_data);
         chk("burst_tx_ready", tx_ready, 1'b1);
         tick();
      end
      tx_valid = 1'b0;
      collect(16, 200);
      for (int i = 0; i < 16; i++) begin
         chk("burst_rx_data", rx_got[i], 8'(i) ^ 8'h99);
         chk("burst_master_saw", sent_q[base+i], 8'(i));
      end

      // ---- RX backpressure: 20 bytes, rx_ready low ----
      rs0 = rs_count;
      for (int i = 0; i < 20; i++) push_byte(8'h40 + 8'(i));
      repeat (150) tick();
      chk("bp_pulses16", rs_count - rs0, 16);
      chk("bp_rx_level", rx_level, 5'd16);
      chk("bp_tx_level", tx_level, 5'd4);
      chk("bp_idle", idle, 1'b0);
      chk("bp_head", rx_data, 8'hD9);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      repeat (20) tick();
      chk("bp_pulses17", rs_count - rs0, 17);
      chk("bp_rx_level2", rx_level, 5'd16);
      chk("bp_tx_level2", tx_level, 5'd3);
      rx_got.delete();
      collect(19, 200);
      for (int i = 0; i < 19; i++) chk("bp_rx_order", rx_got[i], (8'h41 + 8'(i)) ^ 8'h99);
      repeat (3) tick();
      chk("bp_drained_tx", tx_level, 5'd0);
      chk("bp_drained_rx", rx_level, 5'd0);
      chk("bp_drained_idle", idle, 1'b1);

      // ---- simultaneous push+pop on a full TX FIFO ----
      for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
      repeat (150) tick();
      chk("full_rx_level", rx_level, 5'd16);
      for (int i = 0; i < 16; i++) begin
         tx_data  = 8'h90 + 8'(i);
         tx_valid = 1'b1;
         chk("full_fill_ready", tx_ready, 1'b1);
         tick();
      end
      tx_data = 8'hEE;
      chk("full_tx_level", tx_level, 5'd16);
      chk("full_tx_ready", tx_ready, 1'b0);
      tick();
      tx_valid = 1'b0;
      chk("full_reject_level", tx_level, 5'd16);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tx_data  = 8'hA0;
      tx_valid = 1'b1;
      chk("full_pp_ready", tx_ready, 1'b1);
      chk("full_pp_level_before", tx_level, 5'd16);
      tick();
      tx_valid = 1'b0;
      chk("full_pp_level_after", tx_level, 5'd16);
      chk("full_pp_issue", spi_ready_send, 1'b1);
      chk("full_pp_data_in", spi_data_in, 8'h90);
      exp_q.delete();
      for (int i = 1; i < 16; i++) exp_q.push_back((8'h80 + 8'(i)) ^ 8'h99);
      for (int i = 0; i < 16; i++) exp_q.push_back((8'h90 + 8'(i)) ^ 8'h99);
      exp_q.push_back(8'hA0 ^ 8'h99);
      rx_got.delete();
      collect(32, 400);
      for (int i = 0; i < 32; i++) chk("full_rx_order", rx_got[i], exp_q[i]);

      // ---- simultaneous push+pop on an empty RX FIFO ----
      repeat (3) tick();
      push_byte(8'h5A);
      rx_ready = 1'b1;
      w = 0;
      while (!rx_valid && w < 40) begin
         tick();
         w++;
      end
      chk("empty_pp_valid", rx_valid, 1'b1);
      chk("empty_pp_level_before", rx_level, 5'd0);
      chk("empty_pp_data", rx_data, 8'hC3);
      tick();
      rx_ready = 1'b0;
      chk("empty_pp_level_after", rx_level, 5'd0);
      chk("empty_pp_valid_after", rx_valid, 1'b0);

      // ---- watchdog ----
      repeat (3) tick();
`ifdef SPI_SEQ_TIMEOUT_EN
      slave_hold = 60;
      tx_data    = 8'hB1;
      tx_valid   = 1'b1;
      tick();
      tx_data    = 8'hB2;
      tick();
      tx_valid   = 1'b0;
      chk("to_issue", spi_ready_send, 1'b1);
      repeat (32) tick();
      chk("to_err_before", err, 1'b0);
      slave_hold = 3;
      tick();
      chk("to_err_set", err, 1'b1);
      chk("to_no_rx", rx_level, 5'd0);
      chk("to_tx_level", tx_level, 5'd1);
      tick();
      chk("to_next_issue", spi_ready_send, 1'b1);
      chk("to_next_data", spi_data_in, 8'hB2);
      w = 0;
      while (!rx_valid && w < 40) begin
         tick();
         w++;
      end
      chk("to_next_rx", rx_data, 8'h2B);
      tick();
      chk("to_rx_level", rx_level, 5'd1);
      chk("to_err_sticky", err, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_err_clr", err, 1'b0);
`else
      slave_hold = 40;
      tx_data    = 8'hB1;
      tx_valid   = 1'b1;
      tick();
      tx_valid   = 1'b0;
      tick();
      chk("to_issue", spi_ready_send, 1'b1);
      repeat (32) tick();
      chk("to_err_off_32", err, 1'b0);
      tick();
      chk("to_err_off_33", err, 1'b0);
      chk("to_still_busy", idle, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_err_off_clr", err, 1'b0);
      slave_hold = 3;
      w = 0;
      while (!rx_valid && w < 40) begin
         tick();
         w++;
      end
      chk("to_off_rx", rx_data, 8'h28);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
